// File: rtl/register_file_pkg.sv
// register_file_pkg: CPU-wide constants shared by the decode stage and its register file.
package register_file_pkg;
  localparam int DEF_WORD_SIZE  = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int REG_ZERO       = 0;
  localparam int RD_LSB         = 7;
  localparam int RS1_LSB        = 15;
  localparam int RS2_LSB        = 20;
endpackage

// File: rtl/register_file.sv
// register_file: 2R1W register file, x0 hardwired to zero, combinational reads with write-through bypass.
module register_file
  import register_file_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [WORD_SIZE-1:0]  write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr1,
  input  logic [ADDR_WIDTH-1:0] read_addr2,
  output logic [WORD_SIZE-1:0]  read_data1,
  output logic [WORD_SIZE-1:0]  read_data2
);
  localparam int NREGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(REG_ZERO);
  logic [WORD_SIZE-1:0] regs_q [NREGS];
  logic                 wr_hit;
  // reset_n is active-high despite its name; it also masks the bypass
  assign wr_hit = write_enable && write_addr != X0 && !reset_n;
  always_ff @(posedge clock) begin
    if (reset_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_hit) begin
      regs_q[write_addr] <= write_data;
    end
  end
  assign read_data1 = read_addr1 == X0 ? '0
                    : (wr_hit && write_addr == read_addr1) ? write_data : regs_q[read_addr1];
  assign read_data2 = read_addr2 == X0 ? '0
                    : (wr_hit && write_addr == read_addr2) ? write_data : regs_q[read_addr2];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed self-checking bench for register_file.
module tb_register_file;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  int          n_cmp = 0;
  int          n_bad = 0;

  register_file dut (
    .clock(clock), .reset_n(reset_n), .write_enable(write_enable),
    .write_addr(write_addr), .write_data(write_data),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .read_data1(read_data1), .read_data2(read_data2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2);
    reset_n = rst; write_enable = we; write_addr = wa; write_data = wd;
    read_addr1 = ra1; read_addr2 = ra2;
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    drive(1, 0, 0, 0, 5, 31);
    step();
    step();
    drive(1, 0, 0, 0, 5, 31);
    check("rst_x5", read_data1, 32'h0);
    check("rst_x31", read_data2, 32'h0);
    drive(0, 1, 5, 32'hDEADBEEF, 5, 0);
    check("byp_x5", read_data1, 32'hDEADBEEF);
    check("byp_x0", read_data2, 32'h0);
    step();
    drive(0, 0, 0, 0, 5, 5);
    check("rd_x5", read_data1, 32'hDEADBEEF);
    drive(1, 0, 0, 0, 5, 5);
    step();
    drive(0, 0, 0, 0, 5, 5);
    check("clr_x5", read_data1, 32'h0);
    drive(0, 1, 3, 32'h12345678, 0, 0);
    step();
    drive(0, 0, 0, 0, 3, 3);
    check("rd1_x3", read_data1, 32'h12345678);
    check("rd2_x3", read_data2, 32'h12345678);
    drive(0, 1, 0, 32'hFFFFFFFF, 0, 0);
    check("x0_same1", read_data1, 32'h0);
    check("x0_same2", read_data2, 32'h0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    check("x0_next", read_data1, 32'h0);
    drive(0, 1, 7, 32'h1, 0, 0);
    step();
    drive(0, 1, 6, 32'h66, 0, 0);
    step();
    drive(0, 0, 0, 0, 6, 7);
    check("x7_old", read_data2, 32'h1);
    drive(0, 1, 7, 32'hA5A5A5A5, 6, 7);
    check("byp_rd2", read_data2, 32'hA5A5A5A5);
    check("byp_rd1_x6", read_data1, 32'h66);
    step();
    drive(0, 1, 12, 32'hC3C3C3C3, 12, 12);
    check("byp_both1", read_data1, 32'hC3C3C3C3);
    check("byp_both2", read_data2, 32'hC3C3C3C3);
    step();
    drive(0, 0, 4, 32'h44444444, 7, 12);
    check("x7_new", read_data1, 32'hA5A5A5A5);
    check("x12", read_data2, 32'hC3C3C3C3);
    step();
    drive(0, 0, 0, 0, 4, 3);
    check("we0_x4", read_data1, 32'h0);
    check("we0_x3", read_data2, 32'h12345678);
    drive(1, 1, 9, 32'h55, 9, 3);
    check("rst_nobyp", read_data1, 32'h0);
    check("rst_store", read_data2, 32'h12345678);
    step();
    drive(0, 0, 0, 0, 9, 3);
    check("rstpri_x9", read_data1, 32'h0);
    check("rstclr_x3", read_data2, 32'h0);
    for (int i = 1; i < 32; i++) begin
      drive(0, 1, 5'(i), 32'(i * 32'h01010101), 0, 0);
      step();
    end
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 5'(i), 5'(31 - i));
      check($sformatf("sw1_x%0d", i), read_data1, 32'(i * 32'h01010101));
      check($sformatf("sw2_x%0d", 31 - i), read_data2, 32'((31 - i) * 32'h01010101));
    end
    drive(1, 0, 0, 0, 0, 0);
    step();
    drive(0, 1, 1, 32'h0000CAFE, 1, 2);
    step();
    drive(0, 0, 0, 0, 1, 2);
    check("post_rst_x1", read_data1, 32'h0000CAFE);
    check("post_rst_x2", read_data2, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The module SHALL have parameter WORD_SIZE, default 32, giving the data width of every register and data port.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 5, giving the register address width; register count = 2**ADDR_WIDTH (32).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-high (asserted = 1); the name is kept for codebase consistency.
REQ-005 write_enable  input  1  write strobe from the writeback stage.
REQ-006 write_addr  input  ADDR_WIDTH  destination register index.
REQ-007 write_data  input  WORD_SIZE  value to write.
REQ-008 read_addr1  input  ADDR_WIDTH  source register 1 index (rs1).
REQ-009 read_addr2  input  ADDR_WIDTH  source register 2 index (rs2).
REQ-010 read_data1  output  WORD_SIZE  contents of register read_addr1.
REQ-011 read_data2  output  WORD_SIZE  contents of register read_addr2.

Function
REQ-012 Storage SHALL be 2**ADDR_WIDTH registers of WORD_SIZE bits each.
REQ-013 Register 0 SHALL read as all-zero at all times; writes to address 0 are silently discarded.
REQ-014 On a rising clock edge with reset_n=0, write_enable=1 and write_addr!=0, register[write_addr] SHALL take write_data.
REQ-015 With write_enable=0, no register SHALL change.
REQ-016 Reads SHALL be combinational (zero-cycle latency): read_data1/2 follow read_addr1/2 and storage within the same cycle, with no clock involvement.
REQ-017 Write-through bypass: when write_enable=1, write_addr!=0 and write_addr equals a read address, that read port SHALL output write_data combinationally in the same cycle (write-before-read semantics).
REQ-018 Bypass SHALL NOT apply for address 0; read of address 0 returns 0 even if write_addr=0 with write_enable=1.
REQ-019 Both read ports SHALL be fully independent; equal read addresses return identical data.
REQ-020 Simultaneous write and two reads of the same address SHALL produce write_data on both ports (bypass) and update storage at the edge.
REQ-021 No handshake, no stall; every write request is accepted in the cycle presented.
REQ-022 Outputs SHALL never be X/Z after the first reset edge for any in-range address.

Reset
REQ-023 On a rising edge with reset_n=1, all registers SHALL be cleared to 0; reset has priority over a simultaneous write.
REQ-024 While reset_n=1, bypass SHALL be suppressed and read ports SHALL return storage contents (0 after the first reset edge).
REQ-025 Reset asserted mid-operation SHALL clear all prior written values at that edge; first write after deassertion behaves per REQ-014.
REQ-026 Prior to any reset, register contents are unspecified except register 0, which reads 0.

Structure
REQ-027 Single flat module; no sub-modules required; storage as an array, reads as two identical mux+bypass paths (a per-port read function or generate loop is acceptable).
REQ-028 Default WORD_SIZE/ADDR_WIDTH and register-0 index SHALL live in the shared CPU package alongside the decode-stage constants; no typedefs required.
REQ-029 The instance name in the decode stage SHALL remain register_file, fed by instruction bits [19:15]/[24:20] for read addresses.

Verification
REQ-030 Reset: reset_n=1 for one edge after writing x5=0xDEADBEEF -> read_addr1=5 returns 0x00000000.
REQ-031 Write/read: write x3=0x12345678, next cycle read_addr1=3, read_addr2=3 -> both ports 0x12345678.
REQ-032 x0 protection: write_enable=1, write_addr=0, write_data=0xFFFFFFFF -> same cycle and next cycle read of 0 returns 0x00000000.
REQ-033 Bypass: x7 holds 0x1, same cycle write x7=0xA5A5A5A5 with read_addr2=7 -> read_data2=0xA5A5A5A5 before the edge; read_data1 on addr 6 unaffected.
REQ-034 Reset priority: reset_n=1 and write x9=0x55 same edge -> x9 reads 0 afterward.
REQ-035 Sweep: write x1..x31 with value index*0x01010101, read back all pairs -> exact match, x0=0.
